type_switch_sched: RTL and testbench

Scheduler for the two-port type switch in the FHE ALU buffer path. Arbitrates two valid/ready input streams, each carrying a per-beat destination bit, onto the switch's two output ports, and drives the switch's `switch_set` aligned to the switch's internal pipeline. Also regenerates per-output valid flags aligned with the switched data. Enforces per-output downstream credits, because the switch itself cannot stall. Data words go straight from the sources into the switch; this block handles control only.

---
 rtl/type_switch_sched.sv | 74 +++++++
 tb/tb_type_switch_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/type_switch_sched.sv
// type_switch_sched: grant, credit and sw_set/out_valid control for the two-port type switch.
// Define TSW_SCHED_PERF_CNT_EN to add the conflict_cnt performance counter output.
module type_switch_sched #(
  parameter int CREDITS = 4,
  parameter int SW_LAT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  in_valid,
  input  logic [1:0]  in_dest,
  output logic [1:0]  in_ready,
  output logic        sw_set,
  output logic [1:0]  out_valid,
  input  logic [1:0]  credit_ret,
  input  logic        flush_req,
  output logic        flush_done,
  output logic        busy
`ifdef TSW_SCHED_PERF_CNT_EN
  ,
  output logic [31:0] conflict_cnt
`endif
);
  localparam int CW = $clog2(CREDITS + 1);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t                   state_q, state_d;
  logic [1:0][CW-1:0]       cred_q, cred_d;
  logic [SW_LAT-1:0][1:0]   vpipe_q;
  logic                     rr_q, sw_set_q, run, same, conflict;
  logic [1:0]               elig, grant, hit;
  assign run      = state_q == RUN;
  assign same     = in_dest[0] == in_dest[1];
  assign elig[0]  = run & in_valid[0] & (cred_q[in_dest[0]] != '0);
  assign elig[1]  = run & in_valid[1] & (cred_q[in_dest[1]] != '0);
  assign conflict = (&elig) & same;
  // On a same-destination conflict only the stream rr points at wins.
  assign grant    = conflict ? (rr_q ? 2'b10 : 2'b01) : elig;
  assign hit[0]   = (grant[0] & ~in_dest[0]) | (grant[1] & ~in_dest[1]);
  assign hit[1]   = (grant[0] & in_dest[0]) | (grant[1] & in_dest[1]);
  assign in_ready   = grant;
  assign sw_set     = sw_set_q;
  assign out_valid  = vpipe_q[SW_LAT-1];
  assign flush_done = state_q == DONE;
  assign busy       = (|vpipe_q) | ~run;
  always_comb begin
    for (int j = 0; j < 2; j++)
      cred_d[j] = (hit[j] && !credit_ret[j]) ? cred_q[j] - CW'(1) :
                  (credit_ret[j] && !hit[j] && cred_q[j] != CW'(CREDITS)) ? cred_q[j] + CW'(1) : cred_q[j];
    state_d = run ? (flush_req ? DRAIN : RUN) :
              (state_q == DRAIN) ? ((vpipe_q == '0) ? DONE : DRAIN) : RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cred_q   <= {2{CW'(CREDITS)}};
      vpipe_q  <= '0;
      rr_q     <= 1'b0;
      sw_set_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cred_q   <= cred_d;
      vpipe_q  <= {vpipe_q[SW_LAT-2:0], hit};
      rr_q     <= conflict ? ~rr_q : rr_q;
      sw_set_q <= (|grant) ? ((grant[0] & in_dest[0]) | (grant[1] & ~in_dest[1])) : sw_set_q;
    end
  end
`ifdef TSW_SCHED_PERF_CNT_EN
  logic [31:0] conflict_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt_q <= '0;
    else conflict_cnt_q <= conflict_cnt_q + 32'(run & (&in_valid) & same);
  end
`endif
endmodule

// File: tb/tb_type_switch_sched.sv
// tb_type_switch_sched: directed and randomized checks of type_switch_sched against a behavioural model.
module tb_type_switch_sched;
  localparam int CREDITS = 4;
  localparam int SW_LAT  = 3;
  logic clk = 1'b0, rst_n = 1'b0, flush_req = 1'b0, sw_set, flush_done, busy;
  logic [1:0] in_valid = '0, in_dest = '0, credit_ret = '0, in_ready, out_valid;
`ifdef TSW_SCHED_PERF_CNT_EN
  logic [31:0] conflict_cnt;
`endif
  int checks = 0, errors = 0;
  int cred[2], rr, st, sw, conf, gcnt;
  int q[$];
  type_switch_sched #(.CREDITS(CREDITS), .SW_LAT(SW_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_dest(in_dest), .in_ready(in_ready),
    .sw_set(sw_set), .out_valid(out_valid), .credit_ret(credit_ret), .flush_req(flush_req),
    .flush_done(flush_done), .busy(busy)
`ifdef TSW_SCHED_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    cred[0] = CREDITS; cred[1] = CREDITS;
    rr = 0; st = 0; sw = 0; conf = 0;
    q = '{0, 0, 0};
  endtask
  task automatic check_regs();
    int any;
    any = 0;
    foreach (q[i]) any |= q[i];
    chk("sw_set", sw_set, sw);
    chk("out_valid", out_valid, q[0]);
    chk("flush_done", flush_done, st == 2);
    chk("busy", busy, (any != 0) || (st != 0));
  endtask
  task automatic do_reset();
    in_valid = '0; in_dest = '0; credit_ret = '0; flush_req = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", in_ready, 0);
    check_regs();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  // One clock cycle: apply inputs, check grants, advance model, check registered outputs.
  task automatic step(input logic [1:0] v, input logic [1:0] d, input logic [1:0] ret, input logic fl);
    int e0, e1, g, hit, nst, allz;
    in_valid = v; in_dest = d; credit_ret = ret; flush_req = fl;
    #1;
    e0 = (st == 0 && v[0] && cred[d[0]] > 0) ? 1 : 0;
    e1 = (st == 0 && v[1] && cred[d[1]] > 0) ? 1 : 0;
    if (e0 == 1 && e1 == 1 && d[0] == d[1]) begin
      g = (rr == 0) ? 1 : 2;
      rr = 1 - rr;
    end else g = e0 | (e1 << 1);
    if (st == 0 && v == 2'b11 && d[0] == d[1]) conf++;
    chk("in_ready", in_ready, g);
    gcnt += int'(in_ready[0] & v[0]) + int'(in_ready[1] & v[1]);
    hit = 0;
    for (int k = 0; k < 2; k++) if (g[k]) hit |= 1 << d[k];
    for (int j = 0; j < 2; j++) begin
      if (hit[j]) cred[j]--;
      if (ret[j] && cred[j] < CREDITS) cred[j]++;
    end
    if (g != 0) sw = (((g & 1) != 0 && d[0]) || ((g & 2) != 0 && !d[1])) ? 1 : 0;
    allz = 1;
    foreach (q[i]) if (q[i] != 0) allz = 0;
    nst = (st == 0) ? (fl ? 1 : 0) : (st == 1) ? (allz ? 2 : 1) : 0;
    q.push_back(hit);
    void'(q.pop_front());
    @(posedge clk); #1;
    st = nst;
    check_regs();
  endtask
  initial begin
    int sws[4];
    int seen;
    gcnt = 0;
    do_reset();
    // Parallel straight: both granted, sw_set 0, out_valid 11 three cycles later.
    step(2'b11, 2'b10, 2'b00, 1'b0);
    chk("par_sw", sw_set, 0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    chk("par_ov", out_valid, 2'b11);
    // Crossed single: stream 0 to output 1, sw_set holds through idle.
    do_reset();
    step(2'b01, 2'b01, 2'b00, 1'b0);
    chk("cross_sw", sw_set, 1);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    chk("cross_ov", out_valid, 2'b10);
    repeat (3) step(2'b00, 2'b00, 2'b00, 1'b0);
    chk("cross_hold", sw_set, 1);
    // Conflict: alternating winners.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 2'b00, 2'b00, 1'b0);
      sws[i] = int'(sw_set);
    end
    chk("conf_sw0", sws[0], 0);
    chk("conf_sw1", sws[1], 1);
    chk("conf_sw2", sws[2], 0);
    chk("conf_sw3", sws[3], 1);
`ifdef TSW_SCHED_PERF_CNT_EN
    chk("conf_cnt", conflict_cnt, 4);
`endif
    // Credits: exactly CREDITS grants, then one more per return.
    do_reset();
    gcnt = 0;
    repeat (7) step(2'b01, 2'b00, 2'b00, 1'b0);
    chk("cred_grants", gcnt, CREDITS);
    chk("cred_block", in_ready, 0);
    gcnt = 0;
    step(2'b01, 2'b00, 2'b01, 1'b0);
    repeat (4) step(2'b01, 2'b00, 2'b00, 1'b0);
    chk("cred_ret_grant", gcnt, 1);
    // Flush after a grant; valid held during drain must not be granted.
    do_reset();
    step(2'b11, 2'b10, 2'b00, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b1);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step(2'b11, 2'b10, 2'b00, 1'b0);
      if (flush_done) seen = 1;
    end
    chk("flush_seen", seen, 1);
    step(2'b11, 2'b10, 2'b00, 1'b0);
    chk("flush_resume", sw_set, 0);
    // Randomized traffic with credit returns and occasional flushes.
    do_reset();
    for (int i = 0; i < 600; i++)
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)}, 1'($urandom_range(0, 39) == 0));
`ifdef TSW_SCHED_PERF_CNT_EN
    chk("rand_conf_cnt", conflict_cnt, conf);
`endif
    // Reset mid-flight clears everything and restores credits.
    do_reset();
    step(2'b11, 2'b10, 2'b00, 1'b0);
    step(2'b11, 2'b10, 2'b00, 1'b0);
    in_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_ov", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sw", sw_set, 0);
    chk("mid_ready", in_ready, 0);
    do_reset();
    gcnt = 0;
    repeat (6) step(2'b01, 2'b00, 2'b00, 1'b0);
    chk("mid_cred", gcnt, CREDITS);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
